// File: rtl/gshare_history_unit.sv
// gshare front-end helper: owns the global history and the read index,
// tracks in-flight predictions in order, and drives the PHT write port on resolve.
module gshare_history_unit #(
    parameter int ENTRY = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pred_valid,
    input  logic [31:0]              pred_pc,
    output logic                     pred_ready,
    output logic [ENTRY-1:0]         read_index,
    input  logic [1:0]               pht_out,
    output logic                     pred_taken,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    input  logic                     resolve_mispredict,
    output logic [ENTRY-1:0]         write_index,
    input  logic [1:0]               current_state,
    output logic [1:0]               pht_in,
    output logic                     pht_load,
    output logic [ENTRY-1:0]         ghr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY-1:0] ghr_q, ghr_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [ENTRY-1:0] idxMem_q  [DEPTH];
    logic [ENTRY-1:0] snapMem_q [DEPTH];
    logic             dirMem_q  [DEPTH];

    logic queueEmpty;
    logic doPop;
    logic doFlush;
    logic doPush;

    assign queueEmpty = (count_q == '0);
    assign pred_ready = (count_q != CNT_W'(DEPTH));
    assign read_index = pred_pc[ENTRY+1:2] ^ ghr_q;
    assign pred_taken = pht_out[1];

    assign doPop   = resolve_valid && !queueEmpty;
    assign doFlush = doPop && resolve_mispredict;
    // A mispredict redirects fetch, so any push in the same cycle is dropped.
    assign doPush  = pred_valid && pred_ready && !doFlush;

    assign pht_load    = doPop;
    assign write_index = queueEmpty ? '0 : idxMem_q[head_q];
    assign ghr         = ghr_q;
    assign count       = count_q;

    // Two-bit saturating counter update for the resolved branch.
    always_comb begin
        pht_in = current_state;
        if (resolve_taken) begin
            if (current_state != 2'b11) pht_in = current_state + 2'd1;
        end else begin
            if (current_state != 2'b00) pht_in = current_state - 2'd1;
        end
    end

    always_comb begin
        ghr_d   = ghr_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (doFlush) begin
            ghr_d   = {snapMem_q[head_q][ENTRY-2:0], resolve_taken};
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (doPush) begin
                ghr_d  = {ghr_q[ENTRY-2:0], pred_taken};
                tail_d = tail_q + PTR_W'(1);
            end
            if (doPop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (doPush && !doPop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!doPush && doPop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ghr_q   <= ghr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload needs no reset; validity is tracked by head/tail/count.
    always_ff @(posedge clk) begin
        if (doPush) begin
            idxMem_q[tail_q]  <= read_index;
            snapMem_q[tail_q] <= ghr_q;
            dirMem_q[tail_q]  <= pred_taken;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{pred_pc[31:ENTRY+2], pred_pc[1:0], pht_out[0],
                           snapMem_q[head_q][ENTRY-1], dirMem_q[head_q]};

endmodule

// File: tb/tb_gshare_history_unit.sv
// Self-checking bench for gshare_history_unit: directed vector table,
// hand-written overlap sequences, then random traffic against a queue model.
module tb_gshare_history_unit;

    logic        clk;
    logic        reset;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_ready;
    logic [7:0]  read_index;
    logic [1:0]  pht_out;
    logic        pred_taken;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        resolve_mispredict;
    logic [7:0]  write_index;
    logic [1:0]  current_state;
    logic [1:0]  pht_in;
    logic        pht_load;
    logic [7:0]  ghr;
    logic [2:0]  count;

    int testsRun;
    int testsFailed;

    gshare_history_unit #(.ENTRY(8), .DEPTH(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .pred_valid         (pred_valid),
        .pred_pc            (pred_pc),
        .pred_ready         (pred_ready),
        .read_index         (read_index),
        .pht_out            (pht_out),
        .pred_taken         (pred_taken),
        .resolve_valid      (resolve_valid),
        .resolve_taken      (resolve_taken),
        .resolve_mispredict (resolve_mispredict),
        .write_index        (write_index),
        .current_state      (current_state),
        .pht_in             (pht_in),
        .pht_load           (pht_load),
        .ghr                (ghr),
        .count              (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        pv;
        logic [31:0] pc;
        logic [1:0]  po;
        logic        rv;
        logic        rt;
        logic        rm;
        logic [1:0]  cs;
        logic [7:0]  ri;
        logic        pt;
        logic        wiChk;
        logic [7:0]  wi;
        logic [1:0]  pin;
        logic        pl;
        logic        prdy;
        logic [7:0]  ghrN;
        logic [2:0]  cntN;
    } vec_t;

    vec_t vecs [14];

    typedef struct {
        logic [7:0] idx;
        logic [7:0] snap;
    } entry_t;

    entry_t modelQ [$];
    int     modelGhr;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic pv, input logic [31:0] pc,
                                 input logic [1:0] po, input logic rv, input logic rt,
                                 input logic rm, input logic [1:0] cs);
        reset              = rst;
        pred_valid         = pv;
        pred_pc            = pc;
        pht_out            = po;
        resolve_valid      = rv;
        resolve_taken      = rt;
        resolve_mispredict = rm;
        current_state      = cs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] satCounter(input logic [1:0] cs, input logic taken);
        int v;
        v = int'(cs);
        if (taken) v = (v == 3) ? 3 : v + 1;
        else       v = (v == 0) ? 0 : v - 1;
        return 2'(v);
    endfunction

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        applyStimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);

        vecs[0]  = '{1'b0, 1'b1, 32'h40,       2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 8'h10, 1'b1, 1'b1, 8'h00, 2'b00, 1'b0, 1'b1, 8'h01, 3'd1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,        2'b00, 1'b1, 1'b1, 1'b0, 2'b11, 8'h01, 1'b0, 1'b1, 8'h10, 2'b11, 1'b1, 1'b1, 8'h01, 3'd0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 8'h00, 3'd0};
        vecs[3]  = '{1'b0, 1'b1, 32'h100,      2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h40, 1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 1'b1, 8'h00, 3'd1};
        vecs[4]  = '{1'b0, 1'b1, 32'h104,      2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h41, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 8'h00, 3'd2};
        vecs[5]  = '{1'b0, 1'b1, 32'h3FC,      2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'hFF, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 8'h00, 3'd3};
        vecs[6]  = '{1'b0, 1'b1, 32'h12345678, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h9E, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 8'h00, 3'd4};
        vecs[7]  = '{1'b0, 1'b1, 32'h40,       2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 8'h10, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 3'd4};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,        2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 8'h40, 2'b00, 1'b1, 1'b0, 8'h00, 3'd3};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 8'h00, 3'd0};
        vecs[10] = '{1'b0, 1'b1, 32'h40,       2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 8'h10, 1'b1, 1'b1, 8'h00, 2'b00, 1'b0, 1'b1, 8'h01, 3'd1};
        vecs[11] = '{1'b0, 1'b1, 32'h44,       2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 8'h10, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 8'h03, 3'd2};
        vecs[12] = '{1'b0, 1'b1, 32'h48,       2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 8'h11, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 8'h07, 3'd3};
        vecs[13] = '{1'b0, 1'b0, 32'h0,        2'b00, 1'b1, 1'b0, 1'b1, 2'b10, 8'h07, 1'b0, 1'b1, 8'h10, 2'b01, 1'b1, 1'b1, 8'h00, 3'd0};

        // Reset held for two cycles.
        tick();
        tick();
        checkOutput("reset_ghr", 32'(ghr), 32'h0);
        checkOutput("reset_count", 32'(count), 32'h0);
        checkOutput("reset_pred_ready", 32'(pred_ready), 32'h1);
        checkOutput("reset_pht_load", 32'(pht_load), 32'h0);
        checkOutput("reset_write_index", 32'(write_index), 32'h0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].pv, vecs[i].pc, vecs[i].po,
                          vecs[i].rv, vecs[i].rt, vecs[i].rm, vecs[i].cs);
            #1;
            if (!vecs[i].rst) begin
                checkOutput($sformatf("vec%0d_read_index", i), 32'(read_index), 32'(vecs[i].ri));
                checkOutput($sformatf("vec%0d_pred_taken", i), 32'(pred_taken), 32'(vecs[i].pt));
                checkOutput($sformatf("vec%0d_pht_load", i), 32'(pht_load), 32'(vecs[i].pl));
                checkOutput($sformatf("vec%0d_pred_ready", i), 32'(pred_ready), 32'(vecs[i].prdy));
                if (vecs[i].wiChk)
                    checkOutput($sformatf("vec%0d_write_index", i), 32'(write_index), 32'(vecs[i].wi));
                if (vecs[i].pl)
                    checkOutput($sformatf("vec%0d_pht_in", i), 32'(pht_in), 32'(vecs[i].pin));
            end
            tick();
            checkOutput($sformatf("vec%0d_ghr_next", i), 32'(ghr), 32'(vecs[i].ghrN));
            checkOutput($sformatf("vec%0d_count_next", i), 32'(count), 32'(vecs[i].cntN));
        end

        // Push plus correct pop at count==2, then push plus mispredict pop.
        applyStimulus(1'b0, 1'b1, 32'h40, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h80, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
        #1;
        checkOutput("seq_b_read_index", 32'(read_index), 32'h21);
        tick();
        checkOutput("seq_b_count", 32'(count), 32'd2);
        checkOutput("seq_b_ghr", 32'(ghr), 32'h02);
        applyStimulus(1'b0, 1'b1, 32'hC0, 2'b10, 1'b1, 1'b1, 1'b0, 2'b01);
        #1;
        checkOutput("overlap_write_index", 32'(write_index), 32'h10);
        checkOutput("overlap_pht_in", 32'(pht_in), 32'h2);
        checkOutput("overlap_pht_load", 32'(pht_load), 32'h1);
        tick();
        checkOutput("overlap_count", 32'(count), 32'd2);
        checkOutput("overlap_ghr", 32'(ghr), 32'h05);
        applyStimulus(1'b0, 1'b1, 32'h0, 2'b11, 1'b1, 1'b1, 1'b1, 2'b11);
        #1;
        checkOutput("flush_write_index", 32'(write_index), 32'h21);
        checkOutput("flush_pht_in", 32'(pht_in), 32'h3);
        tick();
        checkOutput("flush_ghr", 32'(ghr), 32'h03);
        checkOutput("flush_count", 32'(count), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b01);
        #1;
        checkOutput("empty_resolve_pht_load", 32'(pht_load), 32'h0);
        checkOutput("empty_resolve_write_index", 32'(write_index), 32'h0);
        tick();
        checkOutput("empty_resolve_ghr", 32'(ghr), 32'h03);
        checkOutput("empty_resolve_count", 32'(count), 32'd0);

        // Random traffic against the queue model, starting from a clean reset.
        applyStimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
        tick();
        modelQ.delete();
        modelGhr = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic        rRst, rPv, rRv, rRt, rRm;
            logic [31:0] rPc;
            logic [1:0]  rPo, rCs;
            logic [7:0]  expRi;
            logic        expPush, expPop;
            rRst = ($urandom_range(0, 99) == 0);
            rPv  = ($urandom_range(0, 99) < 60);
            rPc  = $urandom;
            rPo  = 2'($urandom_range(0, 3));
            rRv  = ($urandom_range(0, 99) < 40);
            rRt  = 1'($urandom_range(0, 1));
            rRm  = ($urandom_range(0, 7) == 0);
            rCs  = 2'($urandom_range(0, 3));
            applyStimulus(rRst, rPv, rPc, rPo, rRv, rRt, rRm, rCs);
            #1;
            expRi   = 8'((rPc >> 2) ^ 32'(modelGhr));
            expPop  = rRv && (modelQ.size() != 0);
            expPush = rPv && (modelQ.size() < 4);
            checkOutput("rnd_read_index", 32'(read_index), 32'(expRi));
            checkOutput("rnd_pred_taken", 32'(pred_taken), 32'(rPo[1]));
            checkOutput("rnd_pred_ready", 32'(pred_ready), 32'(modelQ.size() < 4));
            checkOutput("rnd_pht_load", 32'(pht_load), 32'(expPop));
            checkOutput("rnd_write_index", 32'(write_index),
                        (modelQ.size() != 0) ? 32'(modelQ[0].idx) : 32'h0);
            if (expPop)
                checkOutput("rnd_pht_in", 32'(pht_in), 32'(satCounter(rCs, rRt)));
            tick();
            if (rRst) begin
                modelQ.delete();
                modelGhr = 0;
            end else if (expPop && rRm) begin
                modelGhr = ((int'(modelQ[0].snap) << 1) | int'(rRt)) & 8'hFF;
                modelQ.delete();
            end else begin
                if (expPop) void'(modelQ.pop_front());
                if (expPush) begin
                    modelQ.push_back('{expRi, 8'(modelGhr)});
                    modelGhr = ((modelGhr << 1) | int'(rPo[1])) & 8'hFF;
                end
            end
            checkOutput("rnd_ghr", 32'(ghr), 32'(modelGhr));
            checkOutput("rnd_count", 32'(count), 32'(modelQ.size()));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/gshare_history_unit.md
Name: gshare_history_unit

Overview:
- Front-end companion to the 2-bit pattern history table (PHT) of the gshare branch predictor.
- Owns the global history register (GHR) and forms the gshare read index for fetch-time predictions.
- Tracks in-flight predictions in an in-order queue.
- At branch resolution it drives the PHT write port (write index, next 2-bit counter state, load) and repairs the GHR on a mispredict.

Parameters:
- ENTRY, 8, PHT index width and GHR width (PHT has 2**ENTRY counters).
- DEPTH, 4, maximum unresolved branches in flight (power of 2, >=2).

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- pred_valid  in  1  fetch presents a branch needing prediction
- pred_pc  in  32  PC of that branch
- pred_ready  out  1  queue not full; push occurs iff pred_valid && pred_ready
- read_index  out  ENTRY  PHT read index = pred_pc[ENTRY+1:2] ^ ghr (combinational)
- pht_out  in  2  PHT counter at read_index (combinational return)
- pred_taken  out  1  prediction = pht_out[1]
- resolve_valid  in  1  oldest in-flight branch resolved this cycle
- resolve_taken  in  1  actual direction
- resolve_mispredict  in  1  actual != predicted; qualified by resolve_valid
- write_index  out  ENTRY  PHT update index = head entry's index
- current_state  in  2  PHT counter at write_index (combinational return)
- pht_in  out  2  next counter value for write_index
- pht_load  out  1  PHT write enable (PHT writes on negedge of the same cycle)
- ghr  out  ENTRY  current speculative global history
- count  out  $clog2(DEPTH)+1  number of in-flight entries

Behaviour:
- Reset: ghr=0, queue empty, count=0, pred_ready=1, pht_load=0.
- write_index=0 whenever the queue is empty.
- Queue entry: {index[ENTRY], ghr_snap[ENTRY] = GHR before this push, pred_dir}. Circular buffer with head/tail pointers wrapping modulo DEPTH.
- pred_ready = (count != DEPTH). It depends on registered count only; there is no same-cycle pop bypass.
- Push (pred_valid && pred_ready, no flush): enqueue {read_index, ghr, pred_taken}. Next cycle ghr = {ghr[ENTRY-2:0], pred_taken}.
- Pop (resolve_valid && count!=0), combinational in the same cycle:
  - pht_load=1 and write_index = head.index.
  - pht_in = sat-counter(current_state, resolve_taken). Taken: increment, saturate at 2'b11. Not taken: decrement, saturate at 2'b00.
  - Head advances at posedge.
- resolve_valid with empty queue: ignored, pht_load=0, no state change.
- Mispredict pop: PHT is still updated as for a normal pop.
  - Next cycle ghr = {head.ghr_snap[ENTRY-2:0], resolve_taken}.
  - Whole queue is flushed: count=0, head=tail.
  - A push in the same cycle is dropped (fetch is being redirected); the GHR shift from that push is discarded.
- Push + non-mispredict pop in the same cycle: count unchanged and ghr shifts per the push. Legal even when count==DEPTH is false; when full, the push is blocked by pred_ready.
- Latency:
  - Prediction: 0 cycles (combinational via the PHT read port).
  - GHR update: visible 1 cycle after push or mispredict.
  - PHT update: lands on the negedge of the resolve cycle.
- Reset asserted mid-operation: queue discarded, GHR cleared; PHT contents are untouched (not owned here).

Test Plan:
- Reset: assert reset 2 cycles -> ghr=0x00, count=0, pred_ready=1, pht_load=0, write_index=0x00.
- Predict: ghr=0, pred_pc=0x00000040, pht_out=2'b10 -> read_index=0x10, pred_taken=1. Next cycle: ghr=0x01, count=1.
- Correct resolve: head index 0x10, current_state=2'b11, resolve_taken=1, mispredict=0 -> write_index=0x10, pht_in=2'b11 (saturated), pht_load=1. Next cycle: count=0, ghr unchanged at 0x01.
- Full: 4 pushes with pht_out=2'b00 from ghr=0 -> ghr=0x00, count=4, pred_ready=0. A 5th pred_valid causes no push and count stays 4. Pop of entry with current_state=2'b00, taken=0 -> pht_in=2'b00 (saturated).
- Mispredict: 3 pushes with pht_out=2'b11 from ghr=0x00 (ghr becomes 0x07). Resolve head with taken=0, mispredict=1, current_state=2'b10 -> pht_in=2'b01, pht_load=1. Next cycle: ghr=0x00, count=0.
- Simultaneous events:
  - Push + correct pop at count=2 -> count stays 2, ghr shifts in pred_taken.
  - Push + mispredict pop -> count=0, ghr = repaired value only (push dropped).
